// File: rtl/brq_ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// brq_ifu_fetch_ctrl
//
// Prefetch controller between the IF stage and the instruction bus. It issues
// word-aligned fetches over a req/gnt/rvalid bus, tracks up to NUM_REQS
// outstanding responses, and pushes the responses into the IFU fetch FIFO.
// Responses that belong to fetches made before a branch are dropped. The
// controller stops issuing while the FIFO and the in-flight requests together
// would overflow the FIFO.
//
// Optional feature macro: BRQ_FETCH_ERR_STOP_EN
//   If defined, fetching stops after a pushed error response and resumes only
//   on branch_i.
//   If undefined, error responses are pushed and sequential fetching goes on.
//
// Ports:
//   clk_i, rni_ni        clock, asynchronous active-low reset
//   req_i                fetch enable from the IF stage
//   branch_i             redirect fetch this cycle
//   branch_addr_i        redirect target (halfword aligned)
//   busy_o               a request is outstanding or not yet granted
//   fifo_busy_i          occupancy of the upper FIFO entries
//   fifo_clear_o         FIFO clear (equal to branch_i)
//   fifo_addr_o          FIFO address load value (equal to branch_addr_i)
//   fifo_valid_o         push the current response into the FIFO
//   fifo_rdata_o         pushed data (instr_rdata_i passed through)
//   fifo_err_o           pushed error flag (instr_err_i passed through)
//   instr_req_o          bus request
//   instr_addr_o         bus address, word aligned
//   instr_gnt_i          bus grant
//   instr_rvalid_i       bus response valid
//   instr_rdata_i        bus response data
//   instr_err_i          bus response error
// -----------------------------------------------------------------------------
module brq_ifu_fetch_ctrl #(
   parameter int NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_addr_i,
   output logic                busy_o,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i
);

   typedef enum logic {IDLE, WAIT_GNT} state_e;

   state_e                state_q;
   logic [31:0]           fetch_addr_q;
   logic                  pend_branch_q;
   logic [31:0]           pend_addr_q;
   logic [NUM_REQS-1:0]   outstanding_q, outstanding_d;
   logic [NUM_REQS-1:0]   discard_q, discard_d;
   logic                  err_stop_q;

   logic                  slots_free;
   logic                  new_req;
   logic                  room_after_gnt;
   logic                  gnt_acc;
   logic                  retire;
   logic                  discard_new;
   logic [31:0]           branch_tgt;

   function automatic int popcnt(input logic [NUM_REQS-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

   assign branch_tgt = {branch_addr_i[31:2], 2'b00};
   assign slots_free = (popcnt(outstanding_q) + popcnt(fifo_busy_i)) < NUM_REQS;

   // A branch overrides an error stop in its own cycle so the target can issue.
   assign new_req = req_i & (slots_free | branch_i) & ~outstanding_q[NUM_REQS-1]
                    & ~(err_stop_q & ~branch_i);

   // Staying in WAIT_GNT after a grant commits to one more request, so it is
   // allowed only if a slot is still free once the granted request is counted.
   assign room_after_gnt = popcnt(outstanding_q) < (NUM_REQS - 1);

   assign instr_req_o  = (state_q == WAIT_GNT) | new_req;
   assign instr_addr_o = (state_q == IDLE && branch_i) ? branch_tgt
                                                       : {fetch_addr_q[31:2], 2'b00};
   assign gnt_acc      = instr_req_o & instr_gnt_i;
   assign retire       = instr_rvalid_i & outstanding_q[0];

   // A request granted after a branch seen in WAIT_GNT fetches the old
   // sequential address, so its response has to be dropped.
   assign discard_new  = (state_q == WAIT_GNT) & (branch_i | pend_branch_q);

   assign fifo_clear_o = branch_i;
   assign fifo_addr_o  = branch_addr_i;
   assign fifo_valid_o = retire & ~discard_q[0];
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign busy_o       = (|outstanding_q) | instr_req_o;

   // Outstanding entries stay packed from bit 0: retire shifts down first, then
   // a grant claims the lowest free bit.
   always_comb begin
      logic placed;
      outstanding_d = outstanding_q;
      discard_d     = branch_i ? outstanding_q : discard_q;
      placed        = 1'b0;
      if (retire) begin
         outstanding_d = outstanding_d >> 1;
         discard_d     = discard_d >> 1;
      end
      if (gnt_acc) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (!placed && !outstanding_d[i]) begin
               outstanding_d[i] = 1'b1;
               discard_d[i]     = discard_new;
               placed           = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         fetch_addr_q  <= 32'h0;
         pend_branch_q <= 1'b0;
         pend_addr_q   <= 32'h0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         case (state_q)
            IDLE: begin
               // instr_addr_o already selects the branch target when needed.
               if (new_req && instr_gnt_i) begin
                  fetch_addr_q <= instr_addr_o + 32'd4;
               end else begin
                  fetch_addr_q <= instr_addr_o;
               end
               if (new_req && !instr_gnt_i) state_q <= WAIT_GNT;
            end
            WAIT_GNT: begin
               if (instr_gnt_i) begin
                  if (branch_i)           fetch_addr_q <= branch_tgt;
                  else if (pend_branch_q) fetch_addr_q <= pend_addr_q;
                  else                    fetch_addr_q <= fetch_addr_q + 32'd4;
                  pend_branch_q <= 1'b0;
                  if (!(new_req && room_after_gnt)) state_q <= IDLE;
               end else if (branch_i) begin
                  // Bus address must stay stable; remember the target instead.
                  pend_branch_q <= 1'b1;
                  pend_addr_q   <= branch_tgt;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BRQ_FETCH_ERR_STOP_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_stop_q <= 1'b0;
      end else if (branch_i) begin
         err_stop_q <= 1'b0;
      end else if (fifo_valid_o && instr_err_i) begin
         err_stop_q <= 1'b1;
      end
   end
`else
   assign err_stop_q = 1'b0;
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding is a bus protocol error.
   rvalid_has_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding_q[0]);
`endif

endmodule

// File: tb/tb_brq_ifu_fetch_ctrl.sv
module tb_brq_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, branch, gnt, rvalid, rerr;
   logic [31:0] baddr, rdata;
   logic [1:0]  fbusy;
   logic        busy_o, fclr, fvalid, ferr, ireq;
   logic [31:0] faddr, frdata, iaddr;

   int checks = 0;
   int errors = 0;

   brq_ifu_fetch_ctrl #(.NUM_REQS(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(branch),
      .branch_addr_i(baddr), .busy_o(busy_o), .fifo_busy_i(fbusy),
      .fifo_clear_o(fclr), .fifo_valid_o(fvalid), .fifo_addr_o(faddr),
      .fifo_rdata_o(frdata), .fifo_err_o(ferr), .instr_req_o(ireq),
      .instr_addr_o(iaddr), .instr_gnt_i(gnt), .instr_rvalid_i(rvalid),
      .instr_rdata_i(rdata), .instr_err_i(rerr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #3;
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", ireq); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
      checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL rst_fvalid: got %b exp 0", fvalid); end
      checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", iaddr); end
      tick;
      rst_n = 1'b1;
      #3;
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b exp 0", ireq); end
      tick;
   endtask

   task automatic test_back_to_back;
      req = 1; gnt = 1; rvalid = 0; #3;
      checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL b2b_req0: got %b exp 1", ireq); end
      checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL b2b_addr0: got %h exp 0", iaddr); end
      checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL b2b_fvalid0: got %b exp 0", fvalid); end
      tick;
      rvalid = 1; rdata = 32'hA000_0000; #3;
      checks++; if (iaddr !== 32'h4) begin errors++; $display("FAIL b2b_addr4: got %h exp 4", iaddr); end
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL b2b_fvalid1: got %b exp 1", fvalid); end
      checks++; if (frdata !== 32'hA000_0000) begin errors++; $display("FAIL b2b_rdata0: got %h exp a0000000", frdata); end
      tick;
      rdata = 32'hA000_0001; #3;
      checks++; if (iaddr !== 32'h8) begin errors++; $display("FAIL b2b_addr8: got %h exp 8", iaddr); end
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL b2b_fvalid2: got %b exp 1", fvalid); end
      checks++; if (frdata !== 32'hA000_0001) begin errors++; $display("FAIL b2b_rdata1: got %h exp a0000001", frdata); end
      tick;
      req = 0; rdata = 32'hA000_0002; #3;
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL b2b_req_off: got %b exp 0", ireq); end
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL b2b_fvalid3: got %b exp 1", fvalid); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy1: got %b exp 1", busy_o); end
      tick;
      rvalid = 0; #3;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy0: got %b exp 0", busy_o); end
      tick;
   endtask

   task automatic test_branch_outstanding;
      req = 1; gnt = 1; #3;
      checks++; if (iaddr !== 32'hC) begin errors++; $display("FAIL br_addrC: got %h exp c", iaddr); end
      tick;
      #3;
      checks++; if (iaddr !== 32'h10) begin errors++; $display("FAIL br_addr10: got %h exp 10", iaddr); end
      tick;
      branch = 1; baddr = 32'h102; #3;
      checks++; if (fclr !== 1'b1) begin errors++; $display("FAIL br_clear: got %b exp 1", fclr); end
      checks++; if (faddr !== 32'h102) begin errors++; $display("FAIL br_faddr: got %h exp 102", faddr); end
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL br_full_req: got %b exp 0", ireq); end
      tick;
      branch = 0; rvalid = 1; rdata = 32'hB000_0000; #3;
      checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL br_drop0: got %b exp 0", fvalid); end
      checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL br_tgt_addr: got %h exp 100", iaddr); end
      tick;
      rdata = 32'hB000_0001; #3;
      checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL br_drop1: got %b exp 0", fvalid); end
      checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL br_tgt_req: got %b exp 1", ireq); end
      checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL br_tgt_issue: got %h exp 100", iaddr); end
      tick;
      req = 0; rdata = 32'hB000_0002; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL br_new_push: got %b exp 1", fvalid); end
      checks++; if (frdata !== 32'hB000_0002) begin errors++; $display("FAIL br_new_rdata: got %h exp b0000002", frdata); end
      tick;
      rvalid = 0;
   endtask

   task automatic test_branch_wait_gnt;
      req = 1; gnt = 0; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h104) begin errors++; $display("FAIL wg_c1: got req %b addr %h exp 1 104", ireq, iaddr); end
      tick;
      branch = 1; baddr = 32'h200; #3;
      checks++; if (iaddr !== 32'h104) begin errors++; $display("FAIL wg_c2_addr: got %h exp 104", iaddr); end
      checks++; if (fclr !== 1'b1) begin errors++; $display("FAIL wg_c2_clear: got %b exp 1", fclr); end
      tick;
      branch = 0; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h104) begin errors++; $display("FAIL wg_c3: got req %b addr %h exp 1 104", ireq, iaddr); end
      tick;
      gnt = 1; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h104) begin errors++; $display("FAIL wg_gnt: got req %b addr %h exp 1 104", ireq, iaddr); end
      tick;
      rvalid = 1; rdata = 32'hC000_0000; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h200) begin errors++; $display("FAIL wg_tgt: got req %b addr %h exp 1 200", ireq, iaddr); end
      checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL wg_drop: got %b exp 0", fvalid); end
      tick;
      req = 0; rdata = 32'hC000_0001; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL wg_push: got %b exp 1", fvalid); end
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL wg_idle: got %b exp 0", ireq); end
      tick;
      rvalid = 0;
   endtask

   task automatic test_fifo_throttle;
      req = 1; gnt = 1; fbusy = 2'b11; #3;
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL thr_block0: got %b exp 0", ireq); end
      tick;
      #3;
      checks++; if (ireq !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL thr_block1: got req %b busy %b exp 0 0", ireq, busy_o); end
      tick;
      fbusy = 2'b01; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h204) begin errors++; $display("FAIL thr_release: got req %b addr %h exp 1 204", ireq, iaddr); end
      tick;
      req = 0; fbusy = 2'b00; rvalid = 1; rdata = 32'hD000_0000; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL thr_push: got %b exp 1", fvalid); end
      tick;
      rvalid = 0;
   endtask

   task automatic test_addr_wrap;
      req = 0; branch = 1; baddr = 32'hFFFF_FFFE; #3;
      checks++; if (faddr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_faddr: got %h exp fffffffe", faddr); end
      checks++; if (iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_comb_addr: got %h exp fffffffc", iaddr); end
      tick;
      branch = 0; req = 1; gnt = 1; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got req %b addr %h exp 1 fffffffc", ireq, iaddr); end
      tick;
      rvalid = 1; rdata = 32'hE000_0000; #3;
      checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h exp 0", iaddr); end
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL wrap_push: got %b exp 1", fvalid); end
      tick;
      req = 0; rdata = 32'hE000_0001; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL wrap_push2: got %b exp 1", fvalid); end
      tick;
      rvalid = 0;
   endtask

   task automatic test_err;
      req = 1; gnt = 1; #3;
      checks++; if (iaddr !== 32'h4) begin errors++; $display("FAIL err_addr4: got %h exp 4", iaddr); end
      tick;
      rvalid = 1; rerr = 1; rdata = 32'hF000_0000; #3;
      checks++; if (fvalid !== 1'b1 || ferr !== 1'b1) begin errors++; $display("FAIL err_push: got valid %b err %b exp 1 1", fvalid, ferr); end
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h8) begin errors++; $display("FAIL err_req8: got req %b addr %h exp 1 8", ireq, iaddr); end
      tick;
      rerr = 0; rdata = 32'hF000_0001; #3;
      checks++; if (fvalid !== 1'b1 || ferr !== 1'b0) begin errors++; $display("FAIL err_push2: got valid %b err %b exp 1 0", fvalid, ferr); end
`ifdef BRQ_FETCH_ERR_STOP_EN
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL err_stop0: got %b exp 0", ireq); end
      tick;
      rvalid = 0; #3;
      checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL err_stop1: got %b exp 0", ireq); end
      tick;
      branch = 1; baddr = 32'h300; #3;
      checks++; if (ireq !== 1'b1 || iaddr !== 32'h300) begin errors++; $display("FAIL err_resume: got req %b addr %h exp 1 300", ireq, iaddr); end
      tick;
      branch = 0; req = 0; rvalid = 1; rdata = 32'hF000_0002; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL err_resume_push: got %b exp 1", fvalid); end
      tick;
`else
      checks++; if (ireq !== 1'b1 || iaddr !== 32'hC) begin errors++; $display("FAIL err_continue: got req %b addr %h exp 1 c", ireq, iaddr); end
      tick;
      req = 0; rdata = 32'hF000_0002; #3;
      checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL err_drain: got %b exp 1", fvalid); end
      tick;
`endif
      rvalid = 0;
   endtask

   initial begin
      rst_n = 0; req = 0; branch = 0; baddr = 0; gnt = 0;
      rvalid = 0; rdata = 0; rerr = 0; fbusy = 0;
      test_reset;
      test_back_to_back;
      test_branch_outstanding;
      test_branch_wait_gnt;
      test_fifo_throttle;
      test_addr_wrap;
      test_err;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
